// File: rtl/phase_timer.sv
// Down-counting wash-phase timer: reloads from the count ROM on every phase change, pulses timeout at zero.
// Optional pause support is compiled in with `define PHASE_TIMER_PAUSE_EN.
module phase_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       StateFromController,
    input  logic [CNT_W-1:0] CountsNum,
    input  logic             timer_pause,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic [2:0]       phase_q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    logic   load;
    logic   hold;

    assign load = (StateFromController != phase_q);

`ifdef PHASE_TIMER_PAUSE_EN
    assign hold = timer_pause;
`else
    // Pause input is kept on the port for drop-in compatibility but has no effect.
    logic unused_pause;
    assign unused_pause = timer_pause;
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
            phase_q   <= 3'b000;
        end else if (load) begin
            // A phase change aborts whatever was running, including a final decrement.
            phase_q   <= StateFromController;
            remaining <= CountsNum;
            timeout   <= 1'b0;
            if (CountsNum != '0) begin
                state <= COUNT;
                busy  <= 1'b1;
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                end
                COUNT: begin
                    if (hold) begin
                        state <= PAUSED;
                    end else if (remaining == CNT_W'(1)) begin
                        remaining <= '0;
                        timeout   <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else if (remaining != '0) begin
                        remaining <= remaining - CNT_W'(1);
                    end else begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                PAUSED: begin
                    if (!hold) begin
                        state <= COUNT;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    remaining <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
